// File: rtl/agnus_sprite_dma_seq.sv
// Per-line sprite DMA sequencer for the eight hardware sprites.
// Fetches POS/CTL/DATA/DATB from chip RAM in the fixed sprite slots,
// tracks vertical start/stop per channel and drives the Denise
// register-write strobe for each fetched word.
//
// Bus handshake: a fetch is launched on a slot edge (clk7_en & cck);
// dma_req/dma_ptr are then held for one 7MHz cycle. On the following
// clk7_en, reg_wr/reg_addr are held for one 7MHz cycle, and chip_data
// is sampled at the clk7_en edge that ends that cycle.
module agnus_sprite_dma_seq #(
  parameter int         NSPR   = 8,
  parameter int         VFIRST = 25,
  parameter logic [7:0] SLOT0  = 8'h15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clk7_en,
  input  logic                cck,
  input  logic [7:0]          hcc,
  input  logic [10:0]         vpos,
  input  logic                sof,
  input  logic                spr_dma_en,
  input  logic [1:0]          fmode,
  input  logic                cpu_wr,
  input  logic [7:0]          cpu_reg,
  input  logic [15:0]         cpu_data,
  input  logic [15:0]         chip_data,
  output logic                dma_req,
  output logic [20:0]         dma_ptr,
  output logic                reg_wr,
  output logic [7:0]          reg_addr,
  output logic [3*NSPR-1:0]   dbg_state
);

  // Encoding is visible on dbg_state (3 bits per channel, channel 0 lowest).
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH_CTL  = 3'd1,
    S_WAIT_START = 3'd2,
    S_ACTIVE     = 3'd3,
    S_DONE       = 3'd4
  } spr_state_t;

  localparam logic [1:0]  K_POS    = 2'd0;
  localparam logic [1:0]  K_CTL    = 2'd1;
  localparam logic [1:0]  K_DATA   = 2'd2;
  localparam logic [1:0]  K_DATB   = 2'd3;
  localparam logic [10:0] VFIRST_V = 11'(VFIRST);

  spr_state_t  state_q    [NSPR];
  spr_state_t  state_d    [NSPR];
  logic [19:0] ptr_q      [NSPR];
  logic [19:0] ptr_d      [NSPR];
  logic [9:0]  vstart_q   [NSPR];
  logic [9:0]  vstart_d   [NSPR];
  logic [9:0]  vstop_q    [NSPR];
  logic [9:0]  vstop_d    [NSPR];
  logic        pos_zero_q [NSPR];
  logic        pos_zero_d [NSPR];
  logic        ctl_zero_q [NSPR];
  logic        ctl_zero_d [NSPR];

  logic [7:0]  pend_addr;
  logic [7:0]  slot_off;
  logic        slot_hit;
  logic [2:0]  slot_ch;
  logic        slot_b;
  logic [19:0] step;
  logic [9:0]  vline;
  logic        fetch;
  logic [1:0]  fetch_k;
  logic        dma_go;
  logic        cap;
  logic [2:0]  cap_ch;
  logic [1:0]  cap_k;
  logic        cpu_hit;
  logic        cpu_pth;
  logic        cpu_ptl;
  logic        cpu_pos;
  logic        cpu_ctl;
  logic [2:0]  cpu_pch;
  logic [2:0]  cpu_vch;

  // Slot A of sprite n is SLOT0+4n, slot B is SLOT0+4n+2; odd offsets belong to nobody.
  assign slot_off = hcc - SLOT0;
  assign slot_hit = clk7_en && cck && (hcc >= SLOT0) && (slot_off <= 8'd30) && !slot_off[0];
  assign slot_ch  = slot_off[4:2];
  assign slot_b   = slot_off[1];
  assign vline    = vpos[9:0];
  assign step     = (fmode == 2'b00) ? 20'd1 : (fmode == 2'b11) ? 20'd4 : 20'd2;

  // The word on the Denise bus this cycle is the one whose data is being captured.
  assign cap    = clk7_en && reg_wr;
  assign cap_ch = reg_addr[4:2];
  assign cap_k  = reg_addr[1:0];

  assign cpu_hit = clk7_en && cpu_wr;
  assign cpu_pth = cpu_hit && (cpu_reg[7:4] == 4'h9) && !cpu_reg[0];
  assign cpu_ptl = cpu_hit && (cpu_reg[7:4] == 4'h9) && cpu_reg[0];
  assign cpu_pos = cpu_hit && (cpu_reg[7:5] == 3'b101) && (cpu_reg[1:0] == K_POS);
  assign cpu_ctl = cpu_hit && (cpu_reg[7:5] == 3'b101) && (cpu_reg[1:0] == K_CTL);
  assign cpu_pch = cpu_reg[3:1];
  assign cpu_vch = cpu_reg[4:2];

  // Channel next-state: slot decisions, pointer advance, POS/CTL capture, CPU overrides, sof.
  always_comb begin
    for (int i = 0; i < NSPR; i++) begin
      state_d[i]    = state_q[i];
      ptr_d[i]      = ptr_q[i];
      vstart_d[i]   = vstart_q[i];
      vstop_d[i]    = vstop_q[i];
      pos_zero_d[i] = pos_zero_q[i];
      ctl_zero_d[i] = ctl_zero_q[i];
    end
    fetch   = 1'b0;
    fetch_k = K_POS;

    if (slot_hit && !slot_b) begin
      unique case (state_q[slot_ch])
        S_IDLE: begin
          if (vpos == VFIRST_V) begin
            state_d[slot_ch] = S_FETCH_CTL;
            fetch            = 1'b1;
          end
        end
        S_FETCH_CTL: fetch = 1'b1;
        S_WAIT_START: begin
          if (pos_zero_q[slot_ch] && ctl_zero_q[slot_ch]) begin
            state_d[slot_ch] = S_DONE;
          end else if (vline == vstart_q[slot_ch]) begin
            fetch = 1'b1;
            if (vstart_q[slot_ch] == vstop_q[slot_ch]) begin
              state_d[slot_ch] = S_FETCH_CTL;
            end else begin
              state_d[slot_ch] = S_ACTIVE;
              fetch_k          = K_DATB;
            end
          end
        end
        S_ACTIVE: begin
          fetch = 1'b1;
          if (vline == vstop_q[slot_ch]) begin
            state_d[slot_ch] = S_FETCH_CTL;
          end else begin
            fetch_k = K_DATB;
          end
        end
        default: ;
      endcase
    end else if (slot_hit && slot_b) begin
      if (state_q[slot_ch] == S_FETCH_CTL) begin
        fetch            = 1'b1;
        fetch_k          = K_CTL;
        state_d[slot_ch] = S_WAIT_START;
      end else if (state_q[slot_ch] == S_ACTIVE) begin
        fetch   = 1'b1;
        fetch_k = K_DATA;
      end
    end

    // With DMA off the state machine keeps tracking lines but nothing moves on the bus.
    dma_go = fetch && spr_dma_en;
    if (dma_go) ptr_d[slot_ch] = ptr_q[slot_ch] + step;

    if (cap && cap_k == K_POS) begin
      vstart_d[cap_ch]   = {vstart_d[cap_ch][9:8], chip_data[15:8]};
      pos_zero_d[cap_ch] = (chip_data == 16'h0);
    end
    if (cap && cap_k == K_CTL) begin
      vstart_d[cap_ch]   = {chip_data[6], chip_data[2], vstart_d[cap_ch][7:0]};
      vstop_d[cap_ch]    = {chip_data[5], chip_data[1], chip_data[15:8]};
      ctl_zero_d[cap_ch] = (chip_data == 16'h0);
    end

    // CPU pointer writes build on the registered pointer, so a coincident increment is dropped.
    if (cpu_pth) ptr_d[cpu_pch] = {cpu_data[4:0], ptr_q[cpu_pch][14:0]};
    if (cpu_ptl) ptr_d[cpu_pch] = {ptr_q[cpu_pch][19:15], cpu_data[15:1]};
    if (cpu_pos) begin
      vstart_d[cpu_vch]   = {vstart_d[cpu_vch][9:8], cpu_data[15:8]};
      pos_zero_d[cpu_vch] = (cpu_data == 16'h0);
    end
    if (cpu_ctl) begin
      vstart_d[cpu_vch]   = {cpu_data[6], cpu_data[2], vstart_d[cpu_vch][7:0]};
      vstop_d[cpu_vch]    = {cpu_data[5], cpu_data[1], cpu_data[15:8]};
      ctl_zero_d[cpu_vch] = (cpu_data == 16'h0);
    end

    if (clk7_en && sof) begin
      for (int i = 0; i < NSPR; i++) state_d[i] = S_IDLE;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSPR; i++) begin
        state_q[i]    <= S_IDLE;
        ptr_q[i]      <= '0;
        vstart_q[i]   <= '0;
        vstop_q[i]    <= '0;
        pos_zero_q[i] <= 1'b0;
        ctl_zero_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NSPR; i++) begin
        state_q[i]    <= state_d[i];
        ptr_q[i]      <= ptr_d[i];
        vstart_q[i]   <= vstart_d[i];
        vstop_q[i]    <= vstop_d[i];
        pos_zero_q[i] <= pos_zero_d[i];
        ctl_zero_q[i] <= ctl_zero_d[i];
      end
    end
  end

  // Bus pipeline: chip-bus request for one 7MHz cycle, then the Denise write for the next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_req   <= 1'b0;
      dma_ptr   <= '0;
      pend_addr <= '0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
    end else if (clk7_en) begin
      dma_req   <= dma_go;
      dma_ptr   <= dma_go ? {1'b0, ptr_q[slot_ch]} : '0;
      pend_addr <= dma_go ? {3'b101, slot_ch, fetch_k} : '0;
      reg_wr    <= dma_req;
      reg_addr  <= dma_req ? pend_addr : '0;
    end
  end

  // Flatten channel states for observation.
  always_comb begin
    dbg_state = '0;
    for (int i = 0; i < NSPR; i++) dbg_state[3*i +: 3] = state_q[i];
  end

endmodule

// File: doc/agnus_sprite_dma_seq.md
Name: agnus_sprite_dma_seq

Overview:
- Per-line sprite DMA sequencer for all eight sprites.
- Fetches SPRxPOS/CTL/DATA/DATB words from chip RAM in the fixed sprite slots.
- Tracks each sprite's vertical start/stop, advances the sprite pointers, and drives the register-write strobe/address that the Denise sprite shifters consume.
- Sits between the Agnus beam counters/CPU register bus and the chip bus / Denise register bus.

Parameters:
- NSPR, 8, number of sprite channels (fixed 8 for register map).
- VFIRST, 25, first line on which sprite DMA may fetch (line after vertical blank).
- SLOT0, 8'h15, colour-clock of sprite 0 slot A; sprite n uses SLOT0+4n (A) and SLOT0+4n+2 (B).

Ports:
- clk  in  1  28MHz clock
- reset_n  in  1  asynchronous active-low reset
- clk7_en  in  1  7MHz enable; all state updates qualified by it
- cck  in  1  colour-clock strobe (one clk7_en cycle of every two)
- hcc  in  8  horizontal colour-clock counter
- vpos  in  11  vertical beam counter
- sof  in  1  start-of-frame pulse (one cck)
- spr_dma_en  in  1  DMACON DMAEN&SPREN
- fmode  in  2  FMODE[3:2] sprite fetch width
- cpu_wr  in  1  CPU custom-register write strobe
- cpu_reg  in  8  CPU register address [8:1]
- cpu_data  in  16  CPU write data
- chip_data  in  16  chip-bus read data, valid in the cycle after a dma_req
- dma_req  out  1  sprite owns current chip-bus slot
- dma_ptr  out  21  word address [20:1] for current fetch
- reg_wr  out  1  register-write strobe to Denise (aen)
- reg_addr  out  8  Denise register address [8:1], 0xA0+4n+k; k=0 POS,1 CTL,2 DATA,3 DATB

Behaviour:
- Reset (reset_n low, async): all channels IDLE, pointers 0, vstart/vstop 0, dma_req=0, dma_ptr=0, reg_wr=0, reg_addr=0.
- Per-channel state: IDLE, FETCH_CTL, WAIT_START, ACTIVE, DONE. Transitions are evaluated at slot A of that channel, only on cck&clk7_en.
- sof: every channel goes to IDLE (overrides everything else the same cycle).
- IDLE: on vpos==VFIRST -> FETCH_CTL in that same line's slots.
- FETCH_CTL: slot A fetches POS, slot B fetches CTL, then -> WAIT_START.
- Vertical fields are captured from the returned words:
  - vstart = {CTL[6],CTL[2],POS[15:8]}
  - vstop = {CTL[5],CTL[1],CTL[15:8]}
  - Comparisons use vpos[9:0].
  - POS==0 and CTL==0 -> DONE for rest of frame.
- WAIT_START: vpos==vstart -> ACTIVE and fetch data in this line. If vstart==vstop, instead refetch POS/CTL on this line (zero-height sprite, no data fetched).
- ACTIVE: slot A fetches DATB, slot B fetches DATA (DATA last, so Denise arms after B is loaded). vpos==vstop -> fetch POS/CTL in this line instead of data -> WAIT_START.
- Pointer increment after each fetch (word units):
  - fmode 00: +1
  - fmode 01/10: +2
  - fmode 11: +4
  - Pointer wraps modulo 2^20 words.
- Fetch cycle: dma_req=1 with dma_ptr during the slot cck. On the next clk7_en:
  - reg_wr=1 for exactly one clk7_en cycle, with reg_addr.
  - chip_data is sampled for POS/CTL capture in that same cycle.
- spr_dma_en=0: no dma_req, no reg_wr, pointers frozen. State still follows vstart/vstop compares, so re-enable resumes at the correct line without data for skipped lines.
- CPU writes:
  - SPRxPTH (0x90+2n) sets ptr[20:16].
  - SPRxPTL (0x91+2n) sets ptr[15:1].
  - SPRxPOS/CTL (0xA0+4n, 0xA1+4n) update vstart/vstop identically to fetched words.
  - A CPU write in the same cycle as a DMA pointer increment wins; the increment is lost.
- Only one channel can own a slot; slots never overlap by construction. Slots outside SLOT0..SLOT0+30 are ignored.

Test Plan:
- Reset mid-frame with dma_req high -> dma_req, reg_wr, reg_addr, dma_ptr go 0 immediately, before any clk edge; all channels IDLE.
- SPR0PT=0x01000, POS=0x3040, CTL=0x3200, fmode=00 -> line 25 fetches 0x01000/0x01001 with reg_addr 0xA0/0xA1. Lines 0x30,0x31 fetch DATB then DATA (reg_addr 0xA3 then 0xA2), ptr advances +1 per word. Line 0x32 refetches POS/CTL at 0x01006/0x01007.
- Same setup, fmode=11 -> ptr steps by 4 per fetch; data lines use ptr 0x01008, 0x0100C, etc.
- POS=0 and CTL=0 fetched -> channel DONE, no further dma_req for that sprite until sof.
- spr_dma_en dropped for line 0x31 -> no dma_req/reg_wr on that line, ptr unchanged; line 0x32 fetches POS/CTL normally.
- CPU SPR3PTL write coincident with sprite 3 slot-B increment -> ptr equals CPU value, not CPU value+1.
